mul_div_unit: RTL and testbench

//  Multi-cycle multiply/divide unit for the pipelined CPU's EX stage, alongside the ALU.

---
 rtl/mul_div_unit_if.sv | 23 ++
 rtl/mul_div_unit.sv | 150 +++++++++++++++
 tb/tb_mul_div_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/result bundle between the EX stage and the MDU.
// Signals: start, MDUOp, A, B (requester side); busy, HI, LO (MDU side).
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       MDUOp;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, MDUOp, A, B,
        input  busy, HI, LO
    );

    modport slave (
        input  start, MDUOp, A, B,
        output busy, HI, LO
    );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle mult/multu/div/divu with HI/LO pair and busy.
// Ports: clk, reset (sync, active-high); bus (slave): start, MDUOp, A, B in; busy, HI, LO out.
module mul_div_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic           clk,
    input logic           reset,
    mul_div_unit_if.slave bus
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic             wr_q, wr_d;

    // Datapath: every result is computed from the live operands at the
    // accept edge and parked in res_*_q until the counter expires.
    logic [WIDTH-1:0]          a, b;
    logic signed [2*WIDTH-1:0] smul;
    logic [2*WIDTH-1:0]        umul;
    logic                      b_zero, s_ovf;
    logic [WIDTH-1:0]          b_safe;
    logic signed [WIDTH-1:0]   sq, sr;
    logic [WIDTH-1:0]          uq, ur;

    assign a = bus.A;
    assign b = bus.B;

    assign smul = $signed({{WIDTH{a[WIDTH-1]}}, a}) *
                  $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign umul = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    assign b_zero = (b == '0);
    // MIN / -1 overflows; it is patched to LO=MIN, HI=0 below.
    assign s_ovf  = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    // Divisor forced to 1 on the special cases so the dividers never
    // see a zero or overflowing operand pair.
    assign b_safe = (b_zero || s_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;

    assign sq = $signed(a) / $signed(b_safe);
    assign sr = $signed(a) % $signed(b_safe);
    assign uq = a / b_safe;
    assign ur = a % b_safe;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            wr_q     <= wr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        wr_d     = wr_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.MDUOp)
                        OP_MULT: begin
                            state_d  = S_BUSY;
                            cnt_d    = CW'(MULT_CYCLES);
                            res_hi_d = smul[2*WIDTH-1:WIDTH];
                            res_lo_d = smul[WIDTH-1:0];
                            wr_d     = 1'b1;
                        end
                        OP_MULTU: begin
                            state_d  = S_BUSY;
                            cnt_d    = CW'(MULT_CYCLES);
                            res_hi_d = umul[2*WIDTH-1:WIDTH];
                            res_lo_d = umul[WIDTH-1:0];
                            wr_d     = 1'b1;
                        end
                        OP_DIV: begin
                            state_d  = S_BUSY;
                            cnt_d    = CW'(DIV_CYCLES);
                            res_hi_d = s_ovf ? '0 : sr;
                            res_lo_d = s_ovf ? a : sq;
                            wr_d     = !b_zero;
                        end
                        OP_DIVU: begin
                            state_d  = S_BUSY;
                            cnt_d    = CW'(DIV_CYCLES);
                            res_hi_d = ur;
                            res_lo_d = uq;
                            wr_d     = !b_zero;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    if (wr_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy = (state_q == S_BUSY);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed plus random checks of mul_div_unit.
// Reference model uses plain 64-bit arithmetic on HI/LO shadows.
module tb_mul_div_unit;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   fails = 0;

    logic [W-1:0] hi_m = '0;
    logic [W-1:0] lo_m = '0;

    mul_div_unit_if #(.WIDTH(W)) bus ();

    mul_div_unit #(
        .WIDTH(W),
        .MULT_CYCLES(MC),
        .DIV_CYCLES(DC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Updates the HI/LO shadows and returns the expected busy length.
    function automatic int model(input logic [2:0] op,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin
                p = sa * sb;
                hi_m = p[63:32];
                lo_m = p[31:0];
                return MC;
            end
            3'd2: begin
                p = {32'b0, a} * {32'b0, b};
                hi_m = p[63:32];
                lo_m = p[31:0];
                return MC;
            end
            3'd3: begin
                if (b != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    lo_m = q[31:0];
                    hi_m = r[31:0];
                end
                return DC;
            end
            3'd4: begin
                if (b != 0) begin
                    lo_m = a / b;
                    hi_m = a % b;
                end
                return DC;
            end
            3'd5: begin
                hi_m = a;
                return 0;
            end
            3'd6: begin
                lo_m = a;
                return 0;
            end
            default: return 0;
        endcase
    endfunction

    // Issue one op; optionally inject an mtlo attempt after inj busy edges.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inj);
        int n;
        int exp_n;
        @(negedge clk);
        bus.start = 1'b1;
        bus.MDUOp = op;
        bus.A = a;
        bus.B = b;
        exp_n = model(op, a, b);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A = $urandom;
        bus.B = $urandom;
        n = 0;
        while (bus.busy && n < 100) begin
            if (n == inj) begin
                bus.start = 1'b1;
                bus.MDUOp = 3'd6;
                bus.A = 32'h1234;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            n++;
        end
        chk({tag, " busy"}, 64'(n), 64'(exp_n));
        chk({tag, " HI"}, 64'(bus.HI), 64'(hi_m));
        chk({tag, " LO"}, 64'(bus.LO), 64'(lo_m));
    endtask

    initial begin
        logic [2:0] op;
        logic [W-1:0] ra, rb;
        bus.start = 1'b0;
        bus.MDUOp = 3'd0;
        bus.A = '0;
        bus.B = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset HI", 64'(bus.HI), 64'd0);
        chk("reset LO", 64'(bus.LO), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("multu", 3'd2, 32'hFFFFFFFF, 32'd2, -1);
        run_op("mult", 3'd1, 32'hFFFFFFFD, 32'd7, -1);
        run_op("div neg", 3'd3, 32'hFFFFFFF9, 32'd2, -1);
        run_op("divu by0", 3'd4, 32'd7, 32'd0, -1);
        run_op("div by0", 3'd3, 32'd9, 32'd0, -1);
        run_op("div ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 4);
        run_op("mthi", 3'd5, 32'hAB, 32'd0, -1);
        run_op("mtlo", 3'd6, 32'hCD, 32'd0, -1);
        run_op("nop0", 3'd0, 32'h55, 32'd1, -1);
        run_op("nop7", 3'd7, 32'h66, 32'd1, -1);
        run_op("mult inj2", 3'd1, 32'd1234, 32'hFFFFFF00, 2);
        run_op("mult atEN", 3'd1, 32'd77, 32'd3, MC - 1);
        run_op("div atEN", 3'd3, 32'd100, 32'hFFFFFFF9, DC - 1);

        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(1, 6));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: rb = '0;
                1: rb = 32'($urandom_range(0, 9)) - 32'd4;
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), op, ra, rb,
                   $urandom_range(0, 1) == 0 ? -1 : 1);
        end

        // Reset during an op: busy drops, HI/LO clear, no late write.
        @(negedge clk);
        bus.start = 1'b1;
        bus.MDUOp = 3'd1;
        bus.A = 32'd3;
        bus.B = 32'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        hi_m = '0;
        lo_m = '0;
        chk("rst mid busy", 64'(bus.busy), 64'd0);
        chk("rst mid HI", 64'(bus.HI), 64'(hi_m));
        chk("rst mid LO", 64'(bus.LO), 64'(lo_m));
        repeat (MC + 2) @(posedge clk);
        #1;
        chk("rst late HI", 64'(bus.HI), 64'(hi_m));
        chk("rst late LO", 64'(bus.LO), 64'(lo_m));
        chk("rst late busy", 64'(bus.busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
